// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared definitions for the ID/EX forwarding stage.
// Holds the ADDI opcode used as the NOP encoding, the zero word used for
// bubble data, and the default datapath / register-address widths.
package id_ex_fwd_stage_pkg;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefRegAw = 5;

  // A bubble is encoded as "addi x0, x0, 0".
  localparam logic [6:0] OpAddi     = 7'b0010011;
  localparam logic [2:0] Funct3Addi = 3'b000;

  localparam logic [DefXlen-1:0] ZeroWord = '0;

endpackage

// File: rtl/id_ex_fwd_stage_fwd_mux.sv
// Operand forwarding mux for one source operand.
// Picks the lowest-index enabled forwarding source whose destination matches
// rs_addr_i; falls back to register-file data. x0 never forwards.
// Ports:
//   rs_addr_i      source register address
//   rf_data_i      register-file read data
//   fwd_enable_i   per-source write enable
//   fwd_addr_i     packed destination addresses, slice i = source i
//   fwd_data_i     packed result data, slice i = source i
//   fwd_is_load_i  per-source "data not yet valid" flag
//   data_o         resolved operand
//   hit_is_load_o  winning source is a load still in flight
module id_ex_fwd_stage_fwd_mux #(
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5
) (
  input  logic [REG_AW-1:0]         rs_addr_i,
  input  logic [XLEN-1:0]           rf_data_i,
  input  logic [NUM_FWD-1:0]        fwd_enable_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
  input  logic [NUM_FWD-1:0]        fwd_is_load_i,
  output logic [XLEN-1:0]           data_o,
  output logic                      hit_is_load_o
);

  logic found;

  always_comb begin
    data_o        = rf_data_i;
    hit_is_load_o = 1'b0;
    found         = 1'b0;
    // Ascending scan with a found flag gives index 0 (youngest) priority.
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!found && fwd_enable_i[i] && (rs_addr_i != '0) &&
          (fwd_addr_i[i*REG_AW +: REG_AW] == rs_addr_i)) begin
        data_o        = fwd_data_i[i*XLEN +: XLEN];
        hit_is_load_o = fwd_is_load_i[i];
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard detection,
// bubble insertion, flush and a saturating load-use stall counter.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   flush_in                  kill the instruction being captured
//   in_valid, pc, imm, r*_addr, rd_addr, r*_data, r*_used, ins_*  decode side
//   fwd_enable/addr/data/is_load  in-flight writebacks, index 0 youngest
//   stall_out                 decode must hold (combinational)
//   out_valid, output_*       registered EX-side instruction
//   stall_count               saturating count of load-use bubbles
module id_ex_fwd_stage
  import id_ex_fwd_stage_pkg::*;
#(
  parameter int unsigned XLEN    = DefXlen,
  parameter int unsigned REG_AW  = DefRegAw,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      in_valid,
  input  logic [XLEN-1:0]           pc,
  input  logic [XLEN-1:0]           imm,
  input  logic [REG_AW-1:0]         r1_addr,
  input  logic [REG_AW-1:0]         r2_addr,
  input  logic [REG_AW-1:0]         rd_addr,
  input  logic [XLEN-1:0]           r1_data,
  input  logic [XLEN-1:0]           r2_data,
  input  logic                      r1_used,
  input  logic                      r2_used,
  input  logic [6:0]                ins_type,
  input  logic [2:0]                ins_details,
  input  logic                      ins_diff,
  input  logic [NUM_FWD-1:0]        fwd_enable,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  output logic                      stall_out,
  output logic                      out_valid,
  output logic [XLEN-1:0]           output_pc,
  output logic [XLEN-1:0]           output_imm,
  output logic [XLEN-1:0]           output_r1_data,
  output logic [XLEN-1:0]           output_r2_data,
  output logic [REG_AW-1:0]         output_rd_addr,
  output logic [6:0]                output_ins_type,
  output logic [2:0]                output_ins_details,
  output logic                      output_ins_diff,
  output logic [CNT_W-1:0]          stall_count
);

  localparam logic [XLEN-1:0] Zero = XLEN'(ZeroWord);

  logic [XLEN-1:0] r1_res, r2_res;
  logic            r1_hit_load, r2_hit_load;
  logic            hz;

  id_ex_fwd_stage_fwd_mux #(
    .NUM_FWD(NUM_FWD), .XLEN(XLEN), .REG_AW(REG_AW)
  ) u_mux_r1 (
    .rs_addr_i    (r1_addr),
    .rf_data_i    (r1_data),
    .fwd_enable_i (fwd_enable),
    .fwd_addr_i   (fwd_addr),
    .fwd_data_i   (fwd_data),
    .fwd_is_load_i(fwd_is_load),
    .data_o       (r1_res),
    .hit_is_load_o(r1_hit_load)
  );

  id_ex_fwd_stage_fwd_mux #(
    .NUM_FWD(NUM_FWD), .XLEN(XLEN), .REG_AW(REG_AW)
  ) u_mux_r2 (
    .rs_addr_i    (r2_addr),
    .rf_data_i    (r2_data),
    .fwd_enable_i (fwd_enable),
    .fwd_addr_i   (fwd_addr),
    .fwd_data_i   (fwd_data),
    .fwd_is_load_i(fwd_is_load),
    .data_o       (r2_res),
    .hit_is_load_o(r2_hit_load)
  );

  // Mux only flags a load hit for nonzero addresses, so x0 never stalls.
  assign hz        = in_valid && rdy_in && ((r1_used && r1_hit_load) || (r2_used && r2_hit_load));
  assign stall_out = hz && !flush_in;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d, r1_q, r1_d, r2_q, r2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [6:0]        type_q, type_d;
  logic [2:0]        det_q, det_d;
  logic              diff_q, diff_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    rd_d    = rd_q;
    type_d  = type_q;
    det_d   = det_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    if (rdy_in) begin
      if (flush_in || hz || !in_valid) begin
        valid_d = 1'b0;
        pc_d    = Zero;
        imm_d   = Zero;
        r1_d    = Zero;
        r2_d    = Zero;
        rd_d    = '0;
        type_d  = OpAddi;
        det_d   = Funct3Addi;
        diff_d  = 1'b0;
        // Flush outranks the hazard: the bubble is then not a load-use bubble.
        if (!flush_in && hz && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        valid_d = 1'b1;
        pc_d    = pc;
        imm_d   = imm;
        r1_d    = r1_res;
        r2_d    = r2_res;
        rd_d    = rd_addr;
        type_d  = ins_type;
        det_d   = ins_details;
        diff_d  = ins_diff;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      pc_q    <= Zero;
      imm_q   <= Zero;
      r1_q    <= Zero;
      r2_q    <= Zero;
      rd_q    <= '0;
      type_q  <= OpAddi;
      det_q   <= Funct3Addi;
      diff_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      rd_q    <= rd_d;
      type_q  <= type_d;
      det_q   <= det_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid          = valid_q;
  assign output_pc          = pc_q;
  assign output_imm         = imm_q;
  assign output_r1_data     = r1_q;
  assign output_r2_data     = r2_q;
  assign output_rd_addr     = rd_q;
  assign output_ins_type    = type_q;
  assign output_ins_details = det_q;
  assign output_ins_diff    = diff_q;
  assign stall_count        = cnt_q;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Self-checking bench for id_ex_fwd_stage: directed scenarios then random
// traffic, all compared against a behavioural model of the stage.
module tb_id_ex_fwd_stage;

  localparam int unsigned NF = 2;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, flush, in_valid, r1_used, r2_used, ins_diff;
  logic [31:0] pc, imm, r1_data, r2_data;
  logic [4:0]  r1_addr, r2_addr, rd_addr;
  logic [6:0]  ins_type;
  logic [2:0]  ins_details;
  logic        fe[NF];
  logic [4:0]  fa[NF];
  logic [31:0] fd[NF];
  logic        fl[NF];

  logic [NF-1:0]    fwd_enable, fwd_is_load;
  logic [NF*5-1:0]  fwd_addr;
  logic [NF*32-1:0] fwd_data;

  logic          stall_out, out_valid, o_diff;
  logic [31:0]   o_pc, o_imm, o_r1, o_r2;
  logic [4:0]    o_rd;
  logic [6:0]    o_type;
  logic [2:0]    o_det;
  logic [CW-1:0] o_cnt;

  id_ex_fwd_stage #(.XLEN(32), .REG_AW(5), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush), .in_valid(in_valid),
    .pc(pc), .imm(imm), .r1_addr(r1_addr), .r2_addr(r2_addr), .rd_addr(rd_addr),
    .r1_data(r1_data), .r2_data(r2_data), .r1_used(r1_used), .r2_used(r2_used),
    .ins_type(ins_type), .ins_details(ins_details), .ins_diff(ins_diff),
    .fwd_enable(fwd_enable), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .fwd_is_load(fwd_is_load), .stall_out(stall_out), .out_valid(out_valid),
    .output_pc(o_pc), .output_imm(o_imm), .output_r1_data(o_r1), .output_r2_data(o_r2),
    .output_rd_addr(o_rd), .output_ins_type(o_type), .output_ins_details(o_det),
    .output_ins_diff(o_diff), .stall_count(o_cnt)
  );

  // Model of the EX-side register contents.
  logic          m_valid, m_diff;
  logic [31:0]   m_pc, m_imm, m_r1, m_r2;
  logic [4:0]    m_rd;
  logic [6:0]    m_type;
  logic [2:0]    m_det;
  int unsigned   m_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {is_load, data}: first enabled source (youngest first) naming rs.
  function automatic logic [32:0] resolve(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return {1'b0, rf};
    for (int i = 0; i < NF; i++)
      if (fe[i] && fa[i] == rs) return {fl[i], fd[i]};
    return {1'b0, rf};
  endfunction

  task automatic model_nop();
    m_valid = 1'b0; m_pc = 0; m_imm = 0; m_r1 = 0; m_r2 = 0; m_rd = 0;
    m_type = 7'b0010011; m_det = 3'b000; m_diff = 1'b0;
  endtask

  task automatic step();
    logic [32:0] a, b;
    logic        hz;
    for (int i = 0; i < NF; i++) begin
      fwd_enable[i] = fe[i]; fwd_is_load[i] = fl[i];
      fwd_addr[i*5 +: 5] = fa[i]; fwd_data[i*32 +: 32] = fd[i];
    end
    #1;
    a  = resolve(r1_addr, r1_data);
    b  = resolve(r2_addr, r2_data);
    hz = in_valid && rdy && ((r1_used && a[32]) || (r2_used && b[32]));
    check("stall_out", {31'd0, stall_out}, {31'd0, hz && !flush});
    if (rst) begin
      model_nop(); m_cnt = 0;
    end else if (!rdy) begin
      // frozen
    end else if (flush) begin
      model_nop();
    end else if (hz) begin
      model_nop();
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (!in_valid) begin
      model_nop();
    end else begin
      m_valid = 1'b1; m_pc = pc; m_imm = imm; m_r1 = a[31:0]; m_r2 = b[31:0];
      m_rd = rd_addr; m_type = ins_type; m_det = ins_details; m_diff = ins_diff;
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("pc", o_pc, m_pc);
    check("imm", o_imm, m_imm);
    check("r1_data", o_r1, m_r1);
    check("r2_data", o_r2, m_r2);
    check("rd_addr", {27'd0, o_rd}, {27'd0, m_rd});
    check("ins_type", {25'd0, o_type}, {25'd0, m_type});
    check("ins_details", {29'd0, o_det}, {29'd0, m_det});
    check("ins_diff", {31'd0, o_diff}, {31'd0, m_diff});
    check("stall_count", {28'd0, o_cnt}, m_cnt);
  endtask

  task automatic quiet();
    rst = 0; rdy = 1; flush = 0; in_valid = 1; r1_used = 1; r2_used = 1; ins_diff = 1;
    pc = 32'h100; imm = 32'h8; r1_addr = 1; r2_addr = 2; rd_addr = 3;
    r1_data = 32'h11; r2_data = 32'h22; ins_type = 7'b0110011; ins_details = 3'd5;
    for (int i = 0; i < NF; i++) begin fe[i] = 0; fa[i] = 0; fd[i] = 0; fl[i] = 0; end
  endtask

  task automatic hazard_setup();
    quiet();
    fe[0] = 1; fl[0] = 1; fa[0] = 7; fd[0] = 32'hDEAD; r1_addr = 7;
  endtask

  initial begin
    // Reset with every other input unknown.
    rst = 1; rdy = 'x; flush = 'x; in_valid = 'x; r1_used = 'x; r2_used = 'x;
    ins_diff = 'x; pc = 'x; imm = 'x; r1_addr = 'x; r2_addr = 'x; rd_addr = 'x;
    r1_data = 'x; r2_data = 'x; ins_type = 'x; ins_details = 'x;
    for (int i = 0; i < NF; i++) begin fe[i] = 'x; fa[i] = 'x; fd[i] = 'x; fl[i] = 'x; end
    step();
    check("reset_type_addi", {25'd0, o_type}, 32'h13);

    // Youngest source wins.
    quiet(); r1_addr = 5;
    fe[0] = 1; fa[0] = 5; fd[0] = 32'hAAAA;
    fe[1] = 1; fa[1] = 5; fd[1] = 32'hBBBB;
    step();
    check("prio_r1", o_r1, 32'hAAAA);

    // x0 never forwards.
    quiet(); r2_addr = 0; r2_data = 0; fe[0] = 1; fa[0] = 0; fd[0] = 32'h1234;
    step();
    check("x0_r2", o_r2, 32'h0);

    // Load-use: one bubble, then forwarded data from the older stage.
    hazard_setup();
    step();
    check("lu_cnt", {28'd0, o_cnt}, 32'd1);
    fe[0] = 0; fl[0] = 0; fe[1] = 1; fa[1] = 7; fd[1] = 32'hCAFE;
    step();
    check("lu_fwd", o_r1, 32'hCAFE);
    check("lu_valid", {31'd0, out_valid}, 32'd1);

    // Flush during a hazard: bubble, no stall, no count.
    hazard_setup(); flush = 1;
    step();
    check("flush_cnt", {28'd0, o_cnt}, 32'd1);

    // Frozen for three cycles with changing inputs, one of them a hazard.
    quiet(); step();
    for (int k = 0; k < 3; k++) begin
      if (k == 1) hazard_setup(); else quiet();
      rdy = 0; pc = $urandom; r1_data = $urandom; in_valid = 1;
      step();
    end

    // Saturation of the stall counter.
    for (int k = 0; k < (1 << CW) + 2; k++) begin
      hazard_setup();
      step();
    end
    check("sat_cnt", {28'd0, o_cnt}, (1 << CW) - 1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      r1_used = $urandom_range(0, 1); r2_used = $urandom_range(0, 1);
      r1_addr = $urandom_range(0, 3); r2_addr = $urandom_range(0, 3);
      rd_addr = $urandom; pc = $urandom; imm = $urandom;
      r1_data = $urandom; r2_data = $urandom;
      ins_type = $urandom; ins_details = $urandom; ins_diff = $urandom;
      for (int i = 0; i < NF; i++) begin
        fe[i] = $urandom_range(0, 1); fa[i] = $urandom_range(0, 3);
        fd[i] = $urandom; fl[i] = ($urandom_range(0, 2) == 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
